adder_421_feeder: RTL and testbench

Operand gatherer that drives the four-operand input port of the pipelined 4:2:1 adder. Accepts one operand per cycle on a valid/ready stream, packs four consecutive operands into A/B/C/D in arrival order, and widens each by two guard bits. Emits one group per `out_valid` pulse. It sits directly upstream of the adder and is the transmitter for that block's `in_valid` interface.

---
 rtl/adder_421_pkg.sv | 23 ++
 rtl/adder_421_feeder_if.sv | 34 +++
 rtl/adder_421_ext.sv | 24 ++
 rtl/adder_421_feeder.sv | 100 ++++++++++
 tb/tb_adder_421_feeder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_421_pkg.sv
// Shared types and helpers for the 4:2:1 adder feeder and its test environment.
package adder_421_pkg;

  typedef logic [1:0] slot_t;

  localparam int SLOTS   = 4;
  localparam int EXT_MAX = 64;

  // Extends the low in_width bits of data to EXT_MAX bits; callers truncate to their width.
  function automatic logic [EXT_MAX-1:0] ext_operand(input logic [EXT_MAX-1:0] data,
                                                     input logic               signed_mode,
                                                     input int                 in_width = 32);
    logic [EXT_MAX-1:0] res;
    logic               sign_bit;
    sign_bit = signed_mode & data[6'(in_width - 1)];
    res      = data;
    for (int i = 0; i < EXT_MAX; i++) begin
      if (i >= in_width) res[i] = sign_bit;
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_421_feeder_if.sv
// Operand stream in, four-operand group out. in_last exists only with ADDER_421_FEEDER_LAST_EN.
interface adder_421_feeder_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = IN_WIDTH + 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
`ifdef ADDER_421_FEEDER_LAST_EN
  logic                 in_last;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] A;
  logic [OUT_WIDTH-1:0] B;
  logic [OUT_WIDTH-1:0] C;
  logic [OUT_WIDTH-1:0] D;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, A, B, C, D
`ifdef ADDER_421_FEEDER_LAST_EN
    , output in_last
`endif
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, A, B, C, D
`ifdef ADDER_421_FEEDER_LAST_EN
    , input in_last
`endif
  );
endinterface

// File: rtl/adder_421_ext.sv
// Width extender: adds OUT_WIDTH-IN_WIDTH sign or zero bits at the MSB end.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module adder_421_ext #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = IN_WIDTH + 2,
  parameter int SIGNED    = 1
) (
  input  logic [IN_WIDTH-1:0]  data,
  output logic [OUT_WIDTH-1:0] ext
);

  generate
    if (OUT_WIDTH > IN_WIDTH) begin : g_ext
      localparam int PAD = OUT_WIDTH - IN_WIDTH;
      logic fill;
      assign fill = (SIGNED != 0) && data[IN_WIDTH-1];
      assign ext  = {{PAD{fill}}, data};
    end else begin : g_pass
      assign ext = data;
    end
  endgenerate

endmodule

// File: rtl/adder_421_feeder.sv
// Packs four consecutive operands into registered A/B/C/D groups; ADDER_421_FEEDER_LAST_EN adds in_last early close.
// Latency: group appears the cycle after its last operand is accepted.
// Backpressure: in_ready drops only on a group-closing operand while the output group is still unaccepted.
module adder_421_feeder
  import adder_421_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = IN_WIDTH + 2,
  parameter int SIGNED    = 1
) (
  input logic              clk,
  input logic              reset,
  adder_421_feeder_if.slave bus
);

  localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);

  slot_t                cnt;
  logic                 out_valid_q;
  logic                 in_ready;
  logic                 close_grp;
  logic                 in_xfer;
  logic                 out_xfer;
  logic [OUT_WIDTH-1:0] ext_data;
  logic [OUT_WIDTH-1:0] stage_a, stage_b, stage_c;
  logic [OUT_WIDTH-1:0] out_a, out_b, out_c, out_d;
  logic [OUT_WIDTH-1:0] grp_a, grp_b, grp_c, grp_d;

  adder_421_ext #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SIGNED   (SIGNED)
  ) u_ext (
    .data(bus.in_data),
    .ext (ext_data)
  );

`ifdef ADDER_421_FEEDER_LAST_EN
  assign close_grp = (cnt == LAST_SLOT) || bus.in_last;
`else
  assign close_grp = (cnt == LAST_SLOT);
`endif

  assign in_ready = !close_grp || !out_valid_q || bus.out_ready;
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

  // Slots past the closing operand read as zero, which only matters for an early close.
  always_comb begin
    grp_a = (cnt == 2'd0) ? ext_data : stage_a;
    grp_b = (cnt == 2'd1) ? ext_data : ((cnt > 2'd1) ? stage_b : '0);
    grp_c = (cnt == 2'd2) ? ext_data : ((cnt == 2'd3) ? stage_c : '0);
    grp_d = (cnt == 2'd3) ? ext_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      out_valid_q <= 1'b0;
      stage_a     <= '0;
      stage_b     <= '0;
      stage_c     <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_c       <= '0;
      out_d       <= '0;
    end else begin
      if (in_xfer) begin
        if (close_grp) begin
          out_a <= grp_a;
          out_b <= grp_b;
          out_c <= grp_c;
          out_d <= grp_d;
          cnt   <= '0;
        end else begin
          case (cnt)
            2'd0:    stage_a <= ext_data;
            2'd1:    stage_b <= ext_data;
            default: stage_c <= ext_data;
          endcase
          cnt <= cnt + 1'b1;
        end
      end
      // A group completing in the same cycle as an output transfer keeps out_valid high.
      if (in_xfer && close_grp) begin
        out_valid_q <= 1'b1;
      end else if (out_xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.A         = out_a;
  assign bus.B         = out_b;
  assign bus.C         = out_c;
  assign bus.D         = out_d;

endmodule

// File: tb/tb_adder_421_feeder.sv
// Bench for adder_421_feeder: signed and unsigned instances share one stimulus stream and a scoreboard.
module tb_adder_421_feeder;
  import adder_421_pkg::*;

  localparam int IN_W  = 32;
  localparam int OUT_W = 34;

  typedef logic [3:0][IN_W-1:0] raw_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_last;
  logic            out_ready;
  logic [IN_W-1:0] in_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_421_feeder_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus_s ();
  adder_421_feeder_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus_u ();

  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_data   = in_data;
  assign bus_s.out_ready = out_ready;
  assign bus_u.in_valid  = in_valid;
  assign bus_u.in_data   = in_data;
  assign bus_u.out_ready = out_ready;
`ifdef ADDER_421_FEEDER_LAST_EN
  assign bus_s.in_last = in_last;
  assign bus_u.in_last = in_last;
`endif

  adder_421_feeder #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SIGNED(1)) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_s)
  );

  adder_421_feeder #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SIGNED(0)) dut_u (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_u)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] ext_ref(input logic [IN_W-1:0] d, input logic sm);
    logic [63:0] w;
    w = ext_operand(64'(d), sm, IN_W);
    return w[OUT_W-1:0];
  endfunction

  // Cycle model: state compared at each negedge, then advanced with the inputs for the next edge.
  raw_t q[$];
  raw_t part;
  raw_t head;
  raw_t grp;
  int   mcnt;
  logic exp_ov;

  always @(negedge clk) begin : monitor
    logic        exp_rdy, in_x, out_x, close;
    logic [35:0] sum_got, sum_exp;
    if (reset === 1'b1) begin
      mcnt   = 0;
      exp_ov = 1'b0;
      part   = '0;
      q.delete();
    end else begin
`ifdef ADDER_421_FEEDER_LAST_EN
      close = (mcnt == 3) || in_last;
`else
      close = (mcnt == 3);
`endif
      exp_rdy = !close || !exp_ov || out_ready;
      check("in_ready", 64'(bus_s.in_ready), 64'(exp_rdy));
      check("out_valid_s", 64'(bus_s.out_valid), 64'(exp_ov));
      check("out_valid_u", 64'(bus_u.out_valid), 64'(exp_ov));
      if (exp_ov) begin
        if (q.size() == 0) begin
          check("sb_empty", 64'(q.size()), 64'd1);
        end else begin
          head = q[0];
          check("sb_A_s", 64'(bus_s.A), 64'(ext_ref(head[0], 1'b1)));
          check("sb_B_s", 64'(bus_s.B), 64'(ext_ref(head[1], 1'b1)));
          check("sb_C_s", 64'(bus_s.C), 64'(ext_ref(head[2], 1'b1)));
          check("sb_D_s", 64'(bus_s.D), 64'(ext_ref(head[3], 1'b1)));
          check("sb_A_u", 64'(bus_u.A), 64'(ext_ref(head[0], 1'b0)));
          check("sb_D_u", 64'(bus_u.D), 64'(ext_ref(head[3], 1'b0)));
          sum_got = 36'(bus_u.A) + 36'(bus_u.B) + 36'(bus_u.C) + 36'(bus_u.D);
          sum_exp = 36'(head[0]) + 36'(head[1]) + 36'(head[2]) + 36'(head[3]);
          check("sb_sum_u", 64'(sum_got), 64'(sum_exp));
        end
      end
      in_x  = in_valid && exp_rdy;
      out_x = exp_ov && out_ready;
      if (out_x && q.size() > 0) void'(q.pop_front());
      if (in_x) begin
        part[mcnt] = in_data;
        if (close) begin
          for (int j = 0; j < 4; j++) grp[j] = (j <= mcnt) ? part[j] : '0;
          q.push_back(grp);
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
      if (in_x && close) exp_ov = 1'b1;
      else if (out_x) exp_ov = 1'b0;
    end
  end

  task automatic send(input logic [IN_W-1:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n        = 0;
    @(negedge clk);
    while (!bus_s.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus_s.in_ready) check("send_timeout", 64'(bus_s.in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int accepted;
    int cyc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_A", 64'(bus_s.A), 64'd0);
    check("rst_D", 64'(bus_u.D), 64'd0);
    check("rst_rdy", 64'(bus_s.in_ready), 64'd1);
    check("rst_ov", 64'(bus_s.out_valid), 64'd0);

    // Basic group
    @(posedge clk); #1;
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0); send(32'd4, 1'b0);
    @(negedge clk);
    check("basic_ov", 64'(bus_s.out_valid), 64'd1);
    check("basic_A", 64'(bus_s.A), 64'd1);
    check("basic_B", 64'(bus_s.B), 64'd2);
    check("basic_C", 64'(bus_s.C), 64'd3);
    check("basic_D", 64'(bus_s.D), 64'd4);
    @(negedge clk);
    check("basic_ov_clr", 64'(bus_s.out_valid), 64'd0);

    // Sign and zero extension
    @(posedge clk); #1;
    send(32'hFFFF_FFFF, 1'b0); send(32'h8000_0000, 1'b0);
    send(32'h7FFF_FFFF, 1'b0); send(32'h0000_0000, 1'b0);
    @(negedge clk);
    check("sext_A", 64'(bus_s.A), 64'h3_FFFF_FFFF);
    check("sext_B", 64'(bus_s.B), 64'h3_8000_0000);
    check("sext_C", 64'(bus_s.C), 64'h0_7FFF_FFFF);
    check("sext_D", 64'(bus_s.D), 64'h0);
    check("zext_A", 64'(bus_u.A), 64'h0_FFFF_FFFF);
    check("zext_B", 64'(bus_u.B), 64'h0_8000_0000);
    check("zext_C", 64'(bus_u.C), 64'h0_7FFF_FFFF);

    // Backpressure: eighth operand stalls until out_ready rises
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send(32'h10 + IN_W'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h18;
    repeat (3) begin
      @(negedge clk);
      check("bp_rdy_low", 64'(bus_s.in_ready), 64'd0);
      check("bp_hold_A", 64'(bus_s.A), 64'h11);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rdy_up", 64'(bus_s.in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_ov", 64'(bus_s.out_valid), 64'd1);
    check("bp_A2", 64'(bus_s.A), 64'h15);
    check("bp_D2", 64'(bus_s.D), 64'h18);

    // Reset mid-group
    @(posedge clk); #1;
    send(32'h21, 1'b0); send(32'h22, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    send(32'd5, 1'b0); send(32'd6, 1'b0); send(32'd7, 1'b0); send(32'd8, 1'b0);
    @(negedge clk);
    check("mrst_A", 64'(bus_s.A), 64'd5);
    check("mrst_B", 64'(bus_s.B), 64'd6);
    check("mrst_C", 64'(bus_s.C), 64'd7);
    check("mrst_D", 64'(bus_s.D), 64'd8);

`ifdef ADDER_421_FEEDER_LAST_EN
    // Early close on in_last
    @(posedge clk); #1;
    send(32'd9, 1'b0); send(32'd10, 1'b1);
    @(negedge clk);
    check("last_A", 64'(bus_s.A), 64'd9);
    check("last_B", 64'(bus_s.B), 64'd10);
    check("last_C", 64'(bus_s.C), 64'd0);
    check("last_D", 64'(bus_s.D), 64'd0);
    @(posedge clk); #1;
    send(32'd11, 1'b0); send(32'd12, 1'b0); send(32'd13, 1'b0); send(32'd14, 1'b0);
    @(negedge clk);
    check("last_next_A", 64'(bus_s.A), 64'd11);
`endif

    // Random stream of about 120 groups with random gaps and backpressure
    @(posedge clk); #1;
    accepted = 0;
    cyc      = 0;
    while (accepted < 480 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef ADDER_421_FEEDER_LAST_EN
      in_last   = ($urandom_range(0, 7) == 0);
`endif
      @(negedge clk);
      if (in_valid && bus_s.in_ready) accepted++;
      @(posedge clk); #1;
      cyc++;
    end
    check("rand_done", 64'(accepted), 64'd480);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
